// File: rtl/prei_mode_pp_pkg.sv
// Shared widths, bank state encoding and side-register record for the
// prei -> intra best-mode ping-pong buffer.
package prei_mode_pp_pkg;

   localparam int ADDR_W      = 7;
   localparam int DATA_W      = 6;
   localparam int QP_W        = 6;
   localparam int PIC_X_WIDTH = 8;
   localparam int PIC_Y_WIDTH = 8;
   localparam int DEPTH       = 2 ** ADDR_W;
   localparam int NUM_BANKS   = 2;

   // A bank is either being filled / free (EMPTY) or holds a finished CTU (FULL)
   typedef enum logic {
      BANK_EMPTY = 1'b0,
      BANK_FULL  = 1'b1
   } bank_state_t;

   // Per-CTU values captured at prei_done and presented with the read bank
   typedef struct packed {
      logic [QP_W-1:0]        qp;
      logic [PIC_X_WIDTH-1:0] x;
      logic [PIC_Y_WIDTH-1:0] y;
   } side_t;

endpackage

// File: rtl/prei_mode_pp_bank.sv
// One mode bank: DEPTH x DATA_W storage, one write port, one registered
// read port. Only the read output register is reset; the array is not.
module prei_mode_pp_bank
   import prei_mode_pp_pkg::*;
(
   input  logic              clk,
   input  logic              i_srst,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   // Write port: last write to an address wins
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Registered read port, cleared on reset so the downstream sees 0
   always_ff @(posedge clk) begin
      if (i_srst) begin
         r_rdata <= '0;
      end else begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/prei_mode_pp.sv
// Ping-pong buffer of per-CTU best modes between prei_top and the
// intra/encode stage. The writer fills bank[wr_ptr]; prei_done seals it
// (FULL) together with its QP and CTU position. The reader sees
// bank[rd_ptr] while FULL and releases it with rd_done. CTUs leave in
// completion order.
module prei_mode_pp
   import prei_mode_pp_pkg::*;
(
   input  logic                   clk,
   input  logic                   rstn,          // active-HIGH synchronous reset despite the name
   input  logic                   md_we_i,
   input  logic [ADDR_W-1:0]      md_waddr_i,
   input  logic [DATA_W-1:0]      md_wdata_i,
   input  logic                   prei_done_i,
   input  logic [QP_W-1:0]        qp_i,
   input  logic [PIC_X_WIDTH-1:0] ctu_x_i,
   input  logic [PIC_Y_WIDTH-1:0] ctu_y_i,
   output logic                   wr_ready_o,
   output logic                   rd_valid_o,
   input  logic [ADDR_W-1:0]      rd_addr_i,
   output logic [DATA_W-1:0]      rd_data_o,
   output logic [QP_W-1:0]        rd_qp_o,
   output logic [PIC_X_WIDTH-1:0] rd_ctu_x_o,
   output logic [PIC_Y_WIDTH-1:0] rd_ctu_y_o,
   input  logic                   rd_done_i,
   output logic                   err_o
);

   logic        r_wr_ptr;
   logic        r_rd_ptr;
   logic        r_rd_sel;      // rd_ptr at the time the pending read was issued
   logic        r_err;
   side_t       r_rd_side;
   bank_state_t r_state      [NUM_BANKS];
   bank_state_t w_state_next [NUM_BANKS];
   side_t       r_side       [NUM_BANKS];
   side_t       w_side_next  [NUM_BANKS];
   logic [DATA_W-1:0] w_bank_rdata [NUM_BANKS];
   logic [NUM_BANKS-1:0] w_bank_we;
   logic [NUM_BANKS-1:0] w_cap;
   logic [NUM_BANKS-1:0] w_rel;

   side_t w_side_in;
   logic  w_wr_ready;
   logic  w_rd_valid;
   logic  w_wr_fire;
   logic  w_done_fire;
   logic  w_rel_fire;
   logic  w_rd_ptr_next;

   // Handshake flags come straight from registered bank state
   assign w_wr_ready = (r_state[r_wr_ptr] == BANK_EMPTY);
   assign w_rd_valid = (r_state[r_rd_ptr] == BANK_FULL);

   // Writer activity is only honoured while its bank is free; reader release only while FULL
   assign w_wr_fire     = md_we_i     & w_wr_ready;
   assign w_done_fire   = prei_done_i & w_wr_ready;
   assign w_rel_fire    = rd_done_i   & w_rd_valid;
   assign w_rd_ptr_next = r_rd_ptr ^ w_rel_fire;

   assign w_side_in.qp = qp_i;
   assign w_side_in.x  = ctu_x_i;
   assign w_side_in.y  = ctu_y_i;

   generate
      for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
         assign w_bank_we[gi] = w_wr_fire   & (r_wr_ptr == 1'(gi));
         assign w_cap[gi]     = w_done_fire & (r_wr_ptr == 1'(gi));
         assign w_rel[gi]     = w_rel_fire  & (r_rd_ptr == 1'(gi));

         // A bank cannot be sealed and released in the same cycle: sealing
         // needs it EMPTY, releasing needs it FULL
         assign w_state_next[gi] = w_cap[gi] ? BANK_FULL  :
                                   w_rel[gi] ? BANK_EMPTY : r_state[gi];
         assign w_side_next[gi]  = w_cap[gi] ? w_side_in  : r_side[gi];

         prei_mode_pp_bank u_bank (
            .clk     (clk),
            .i_srst  (rstn),
            .i_we    (w_bank_we[gi]),
            .i_waddr (md_waddr_i),
            .i_wdata (md_wdata_i),
            .i_raddr (rd_addr_i),
            .o_rdata (w_bank_rdata[gi])
         );
      end
   endgenerate

   // Bank state and side registers
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
         if (rstn) begin
            r_state[i] <= BANK_EMPTY;
            r_side[i]  <= '0;
         end else begin
            r_state[i] <= w_state_next[i];
            r_side[i]  <= w_side_next[i];
         end
      end
   end

   // Pointers toggle on each accepted seal / release
   always_ff @(posedge clk) begin
      if (rstn) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_rd_sel <= 1'b0;
      end else begin
         r_wr_ptr <= r_wr_ptr ^ w_done_fire;
         r_rd_ptr <= w_rd_ptr_next;
         r_rd_sel <= r_rd_ptr;
      end
   end

   // Read-bank side info tracks the bank that will be rd_ptr next cycle, so
   // it is coherent with rd_valid_o after a seal or release
   always_ff @(posedge clk) begin
      if (rstn) begin
         r_rd_side <= '0;
      end else begin
         r_rd_side <= w_side_next[w_rd_ptr_next];
      end
   end

   // Sticky misuse flag: writer touched a bank that was not free
   always_ff @(posedge clk) begin
      if (rstn) begin
         r_err <= 1'b0;
      end else if ((md_we_i | prei_done_i) & ~w_wr_ready) begin
         r_err <= 1'b1;
      end
   end

   assign wr_ready_o = w_wr_ready;
   assign rd_valid_o = w_rd_valid;
   assign rd_data_o  = w_bank_rdata[r_rd_sel];
   assign rd_qp_o    = r_rd_side.qp;
   assign rd_ctu_x_o = r_rd_side.x;
   assign rd_ctu_y_o = r_rd_side.y;
   assign err_o      = r_err;

endmodule
